// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: req/ack handshake with wake settle delay and idle hysteresis.
// Optional wake statistics counter enabled by defining CLK_GATE_STATS_EN.
module clk_gate_ctrl #(
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        busy,
    input  logic        force_on,
    output logic        gate_en,
    output logic        ack,
    output logic [1:0]  state,
    output logic [15:0] wake_count
);

    localparam int unsigned WCNT_W = 8;
    localparam int unsigned ICNT_W = 16;
    localparam int unsigned WC_W   = 16;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAKE = 2'd1,
        ST_ON   = 2'd2,
        ST_IDLE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_gate_en;
    logic                w_gate_nxt;
    logic                r_ack;
    logic                w_ack_nxt;
    logic [WCNT_W-1:0]   r_wcnt;
    logic [WCNT_W-1:0]   w_wcnt_nxt;
    logic [ICNT_W-1:0]   r_icnt;
    logic [ICNT_W-1:0]   w_icnt_nxt;
    logic                w_want;

    assign w_want = req | force_on;

    // State and output registers; reset clears gate_en/ack immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_OFF;
            r_gate_en <= 1'b0;
            r_ack     <= 1'b0;
            r_wcnt    <= '0;
            r_icnt    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gate_en <= w_gate_nxt;
            r_ack     <= w_ack_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_icnt    <= w_icnt_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gate_nxt  = r_gate_en;
        w_ack_nxt   = r_ack;
        w_wcnt_nxt  = r_wcnt;
        w_icnt_nxt  = r_icnt;

        unique case (r_state)
            ST_OFF: begin
                w_gate_nxt = 1'b0;
                w_ack_nxt  = 1'b0;
                if (w_want) begin
                    w_state_nxt = ST_WAKE;
                    w_gate_nxt  = 1'b1;
                    w_wcnt_nxt  = WCNT_W'(WAKE_CYCLES - 1);
                end
            end
            ST_WAKE: begin
                w_gate_nxt = 1'b1;
                w_ack_nxt  = 1'b0;
                if (r_wcnt == '0) begin
                    w_state_nxt = ST_ON;
                    w_ack_nxt   = w_want;
                end else begin
                    w_wcnt_nxt = r_wcnt - WCNT_W'(1);
                end
            end
            ST_ON: begin
                w_gate_nxt = 1'b1;
                w_ack_nxt  = w_want;
                if (!w_want && !busy) begin
                    w_state_nxt = ST_IDLE;
                    w_icnt_nxt  = ICNT_W'(IDLE_CYCLES - 1);
                    w_ack_nxt   = 1'b0;
                end
            end
            ST_IDLE: begin
                w_gate_nxt = 1'b1;
                w_ack_nxt  = 1'b0;
                // A new request beats an expiring idle window.
                if (w_want) begin
                    w_state_nxt = ST_ON;
                    w_ack_nxt   = 1'b1;
                end else if (busy) begin
                    w_icnt_nxt = ICNT_W'(IDLE_CYCLES - 1);
                end else if (r_icnt == '0) begin
                    w_state_nxt = ST_OFF;
                    w_gate_nxt  = 1'b0;
                end else begin
                    w_icnt_nxt = r_icnt - ICNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_gate_nxt  = 1'b0;
                w_ack_nxt   = 1'b0;
            end
        endcase
    end

    assign gate_en = r_gate_en;
    assign ack     = r_ack;
    assign state   = r_state;

`ifdef CLK_GATE_STATS_EN
    logic [WC_W-1:0] r_wake_count;
    logic            w_wake_start;

    assign w_wake_start = (r_state == ST_OFF) && w_want;

    // Saturating count of OFF->WAKE transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wake_count <= '0;
        end else if (w_wake_start && (r_wake_count != {WC_W{1'b1}})) begin
            r_wake_count <= r_wake_count + WC_W'(1);
        end
    end

    assign wake_count = r_wake_count;
`else
    assign wake_count = '0;
`endif

endmodule
